// File: rtl/risc_v_mike_pkg.sv
`default_nettype none
// ============================================================================
// Module   : risc_v_mike_pkg
// Brief    : Shared widths and types for the risc_v_mike core: data width,
//            RV32 register-file depth, register address type and the
//            write-port bundle used by the integer register file.
// Revision : 1.0 - initial release
// ============================================================================
package risc_v_mike_pkg;

    localparam int DATA_32_W          = 32;
    localparam int REG_FILE_DEPTH_RV32 = 32;
    localparam int REG_ADDR_W         = $clog2(REG_FILE_DEPTH_RV32);

    typedef logic [REG_ADDR_W-1:0] t_register_addr;

    // One register-file write port: enable, destination and data.
    typedef struct packed {
        logic                 we;
        t_register_addr       waddr;
        logic [DATA_32_W-1:0] wdata;
    } t_rf_wr_port;

endpackage
`default_nettype wire

// File: rtl/risc_v_mike_reg_file_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : risc_v_mike_reg_file_sb_if
// Brief    : Bundle of read, write and scoreboard signals between the
//            pipeline (master) and the integer register file (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface risc_v_mike_reg_file_sb_if
    import risc_v_mike_pkg::*;
#(
    parameter int DATA_W       = DATA_32_W,
    parameter int ADDR_W       = REG_ADDR_W,
    parameter int NUM_RD_PORTS = 2
);

    logic [NUM_RD_PORTS-1:0][ADDR_W-1:0] rd_addr;
    logic [NUM_RD_PORTS-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD_PORTS-1:0]             rd_busy;

    logic                                alu_we;
    logic [ADDR_W-1:0]                   alu_waddr;
    logic [DATA_W-1:0]                   alu_wdata;

    logic                                mem_we;
    logic [ADDR_W-1:0]                   mem_waddr;
    logic [DATA_W-1:0]                   mem_wdata;

    logic                                sb_set;
    logic [ADDR_W-1:0]                   sb_set_addr;

    logic [ADDR_W:0]                     pending_cnt;
    logic                                sb_err;

    // Pipeline side: drives addresses, write ports and scoreboard set.
    modport master (
        output rd_addr,
        output alu_we, alu_waddr, alu_wdata,
        output mem_we, mem_waddr, mem_wdata,
        output sb_set, sb_set_addr,
        input  rd_data, rd_busy, pending_cnt, sb_err
    );

    // Register-file side.
    modport slave (
        input  rd_addr,
        input  alu_we, alu_waddr, alu_wdata,
        input  mem_we, mem_waddr, mem_wdata,
        input  sb_set, sb_set_addr,
        output rd_data, rd_busy, pending_cnt, sb_err
    );

endinterface
`default_nettype wire

// File: rtl/risc_v_mike_rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : risc_v_mike_rf_scoreboard
// Brief    : Per-register pending-load bits. Decode sets a bit when it issues
//            a load, load writeback clears it. Keeps a registered population
//            count and a sticky flag for hazards that escaped decode.
// Revision : 1.0 - initial release
// ============================================================================
module risc_v_mike_rf_scoreboard #(
    parameter int REG_FILE_DEPTH = 32,
    parameter int ADDR_W         = $clog2(REG_FILE_DEPTH)
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      i_sb_set,
    input  wire logic [ADDR_W-1:0]         i_sb_set_addr,
    input  wire logic                      i_mem_we,
    input  wire logic [ADDR_W-1:0]         i_mem_waddr,
    input  wire logic                      i_alu_we,
    input  wire logic [ADDR_W-1:0]         i_alu_waddr,
    output logic      [REG_FILE_DEPTH-1:0] o_sb_bits,
    output logic      [ADDR_W:0]           o_pending_cnt,
    output logic                           o_sb_err
);

    localparam int c_CNT_W = ADDR_W + 1;

    logic [REG_FILE_DEPTH-1:0] r_bits;
    logic [c_CNT_W-1:0]        r_cnt;
    logic                      r_err;

    logic [REG_FILE_DEPTH-1:0] w_set;
    logic [REG_FILE_DEPTH-1:0] w_clr;
    logic [REG_FILE_DEPTH-1:0] w_next;
    logic [c_CNT_W-1:0]        w_cnt;
    logic                      w_set_nz;
    logic                      w_mem_nz;
    logic                      w_alu_nz;
    logic                      w_err_now;

    // Next bit vector (set beats clear on the same address) and its popcount.
    always_comb begin
        w_set    = '0;
        w_clr    = '0;
        w_set_nz = i_sb_set && (i_sb_set_addr != '0);
        w_mem_nz = i_mem_we && (i_mem_waddr != '0);
        if (w_set_nz) begin
            w_set[i_sb_set_addr] = 1'b1;
        end
        if (w_mem_nz) begin
            w_clr[i_mem_waddr] = 1'b1;
        end
        w_next    = (r_bits & ~w_clr) | w_set;
        w_next[0] = 1'b0;
        w_cnt     = '0;
        for (int i = 0; i < REG_FILE_DEPTH; i++) begin
            w_cnt = w_cnt + c_CNT_W'(w_next[i]);
        end
    end

    // Hazards the pipeline should never produce; a load re-issued to a
    // register whose outstanding load retires this same cycle is legal.
    always_comb begin
        w_alu_nz  = i_alu_we && (i_alu_waddr != '0);
        w_err_now = 1'b0;
        if (w_alu_nz && w_mem_nz && (i_alu_waddr == i_mem_waddr)) begin
            w_err_now = 1'b1;
        end
        if (w_set_nz && r_bits[i_sb_set_addr] &&
            !(w_mem_nz && (i_mem_waddr == i_sb_set_addr))) begin
            w_err_now = 1'b1;
        end
        if (w_mem_nz && !r_bits[i_mem_waddr]) begin
            w_err_now = 1'b1;
        end
        if (w_alu_nz && r_bits[i_alu_waddr]) begin
            w_err_now = 1'b1;
        end
    end

    // Scoreboard state, pending count and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bits <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
        end else begin
            r_bits <= w_next;
            r_cnt  <= w_cnt;
            r_err  <= r_err | w_err_now;
        end
    end

    assign o_sb_bits     = r_bits;
    assign o_pending_cnt = r_cnt;
    assign o_sb_err      = r_err;

endmodule
`default_nettype wire

// File: rtl/risc_v_mike_reg_file_sb.sv
`default_nettype none
// ============================================================================
// Module   : risc_v_mike_reg_file_sb
// Brief    : Integer register file with two write ports (ALU, load), x0 tied
//            to zero, optional write-to-read bypass and a pending-load
//            scoreboard for load-use hazard detection.
//            The write-port bundle is the shared RV32 struct, so DATA_W and
//            ADDR_W must not exceed DATA_32_W and REG_ADDR_W.
// Revision : 1.0 - initial release
// ============================================================================
module risc_v_mike_reg_file_sb
    import risc_v_mike_pkg::*;
#(
    parameter int DATA_W         = DATA_32_W,
    parameter int REG_FILE_DEPTH = REG_FILE_DEPTH_RV32,
    parameter int ADDR_W         = $clog2(REG_FILE_DEPTH),
    parameter int NUM_RD_PORTS   = 2,
    parameter int BYPASS_EN      = 1
) (
    input wire logic                   clk,
    input wire logic                   rst,
    risc_v_mike_reg_file_sb_if.slave   rf_if
);

    localparam int c_ALU_PORT = 0;
    localparam int c_MEM_PORT = 1;

    t_rf_wr_port [1:0]                         w_wr;
    logic [REG_FILE_DEPTH-1:0][DATA_W-1:0]     w_regs;
    logic [REG_FILE_DEPTH-1:0]                 w_sb_bits;

    // Pack both writeback ports into the shared write-port struct.
    always_comb begin
        w_wr[c_ALU_PORT].we    = rf_if.alu_we;
        w_wr[c_ALU_PORT].waddr = t_register_addr'(rf_if.alu_waddr);
        w_wr[c_ALU_PORT].wdata = DATA_32_W'(rf_if.alu_wdata);
        w_wr[c_MEM_PORT].we    = rf_if.mem_we;
        w_wr[c_MEM_PORT].waddr = t_register_addr'(rf_if.mem_waddr);
        w_wr[c_MEM_PORT].wdata = DATA_32_W'(rf_if.mem_wdata);
    end

    // x0 has no storage.
    assign w_regs[0] = '0;

    for (genvar i = 1; i < REG_FILE_DEPTH; i++) begin : g_reg
        logic [DATA_W-1:0] r_q;
        logic              w_alu_hit;
        logic              w_mem_hit;

        assign w_alu_hit = w_wr[c_ALU_PORT].we && (w_wr[c_ALU_PORT].waddr == t_register_addr'(i));
        assign w_mem_hit = w_wr[c_MEM_PORT].we && (w_wr[c_MEM_PORT].waddr == t_register_addr'(i));

        // Register storage; load data wins over ALU data on a collision.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
            end else if (w_mem_hit) begin
                r_q <= w_wr[c_MEM_PORT].wdata[DATA_W-1:0];
            end else if (w_alu_hit) begin
                r_q <= w_wr[c_ALU_PORT].wdata[DATA_W-1:0];
            end
        end

        assign w_regs[i] = r_q;
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_nz;
        logic              w_byp_mem;
        logic              w_byp_alu;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_addr = rf_if.rd_addr[p];

        // Read mux: bypass the in-flight write (load first), else flop value;
        // a load retiring this cycle masks busy because its data is forwarded.
        always_comb begin
            w_nz      = (w_addr != '0);
            w_byp_mem = (BYPASS_EN != 0) && w_nz && w_wr[c_MEM_PORT].we &&
                        (w_wr[c_MEM_PORT].waddr == t_register_addr'(w_addr));
            w_byp_alu = (BYPASS_EN != 0) && w_nz && w_wr[c_ALU_PORT].we &&
                        (w_wr[c_ALU_PORT].waddr == t_register_addr'(w_addr));
            w_data    = '0;
            w_busy    = 1'b0;
            if (!rst) begin
                if (w_byp_mem) begin
                    w_data = w_wr[c_MEM_PORT].wdata[DATA_W-1:0];
                end else if (w_byp_alu) begin
                    w_data = w_wr[c_ALU_PORT].wdata[DATA_W-1:0];
                end else begin
                    w_data = w_regs[w_addr];
                end
                w_busy = w_sb_bits[w_addr] && !w_byp_mem;
            end
        end

        assign rf_if.rd_data[p] = w_data;
        assign rf_if.rd_busy[p] = w_busy;
    end

    risc_v_mike_rf_scoreboard #(
        .REG_FILE_DEPTH (REG_FILE_DEPTH),
        .ADDR_W         (ADDR_W)
    ) u_scoreboard (
        .clk           (clk),
        .rst           (rst),
        .i_sb_set      (rf_if.sb_set),
        .i_sb_set_addr (rf_if.sb_set_addr),
        .i_mem_we      (rf_if.mem_we),
        .i_mem_waddr   (rf_if.mem_waddr),
        .i_alu_we      (rf_if.alu_we),
        .i_alu_waddr   (rf_if.alu_waddr),
        .o_sb_bits     (w_sb_bits),
        .o_pending_cnt (rf_if.pending_cnt),
        .o_sb_err      (rf_if.sb_err)
    );

endmodule
`default_nettype wire

// File: doc/risc_v_mike_reg_file_sb.md
Name: risc_v_mike_reg_file_sb

Overview:
Parametrised successor to the core's integer register file, sized for the RV32I 32-entry set. Features:
- configurable number of read ports
- two write ports: ALU writeback and memory/load writeback
- x0 hardwired to zero
- optional write-to-read bypass
- per-register pending-write scoreboard, so decode can detect load-use hazards and stall

Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- DATA_W, 32, register width in bits
- REG_FILE_DEPTH, 32, number of architectural registers; power of two, >= 2
- ADDR_W, $clog2(REG_FILE_DEPTH), register address width (derived; do not override)
- NUM_RD_PORTS, 2, number of independent read ports (1..4)
- BYPASS_EN, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see flop contents only

Ports:
- clk  in  1  core clock
- rst  in  1  reset; one clock, synchronous and active-high, name matches codebase
- rd_addr  in  NUM_RD_PORTS x ADDR_W  read addresses (rs1, rs2, ...)
- rd_data  out  NUM_RD_PORTS x DATA_W  read data, combinational from rd_addr
- rd_busy  out  NUM_RD_PORTS  addressed register has an outstanding load write
- alu_we  in  1  ALU writeback enable
- alu_waddr  in  ADDR_W  ALU writeback destination
- alu_wdata  in  DATA_W  ALU writeback data
- mem_we  in  1  load writeback enable
- mem_waddr  in  ADDR_W  load writeback destination
- mem_wdata  in  DATA_W  load writeback data
- sb_set  in  1  decode issued a load; mark sb_set_addr pending
- sb_set_addr  in  ADDR_W  load destination register
- pending_cnt  out  ADDR_W+1  number of registers currently pending
- sb_err  out  1  sticky error flag (see Behaviour)

Behaviour:
Reset
- rst high at posedge: all registers, all scoreboard bits, pending_cnt and sb_err become 0.
- During and after reset, rd_data = 0 and rd_busy = 0 on all ports.

Writes
- Committed at posedge when the enable is high and the address is != 0.
- Writes to x0 are silently dropped. x0 always reads 0, never becomes busy, and bypass never applies to it.
- alu and mem target the same address in the same cycle: mem data wins. sb_err is set, because the pipeline must never produce this.

Reads
- Combinational, zero latency.
- BYPASS_EN=1: if a write with enable high targets rd_addr this cycle, rd_data returns that write's data, using the same mem-over-alu priority. Otherwise rd_data returns the flop contents.
- BYPASS_EN=0: rd_data returns flop contents; new data is visible one cycle after the write edge.

Scoreboard (one bit per register; bit 0 tied to 0)
- Set at posedge when sb_set = 1 and sb_set_addr != 0.
- Cleared at posedge when mem_we = 1 on that address.
- Set and clear on the same address in the same cycle: bit ends set, because a new load is outstanding.
- sb_set on an already-pending register: bit stays set, pending_cnt unchanged, sb_err set.
- mem_we to a non-pending, non-zero address: the write still happens, sb_err set.
- alu_we to a pending register: the write happens, the bit is unchanged, sb_err set (WAW hazard escaped decode).
- rd_busy[p] = bit[rd_addr[p]].
  - BYPASS_EN=1: rd_busy[p] is additionally masked to 0 when mem_we clears that address this cycle, since the bypassed data is valid.
  - BYPASS_EN=0: no masking.
- pending_cnt is a registered population count of scoreboard bits, updated every edge. The +1/-1 per cycle must stay consistent with the bits; it never wraps, max is REG_FILE_DEPTH-1.

sb_err
- Sticky until rst. Diagnostic only; never blocks writes.

Decomposition:
- In risc_v_mike_pkg: DATA_32_W (existing); REG_FILE_DEPTH_RV32 = 32; t_register_addr sized from it; struct t_rf_wr_port {we, waddr, wdata}. The two write ports are packed as t_rf_wr_port inside the block.
- One natural sub-module: risc_v_mike_rf_scoreboard. It holds the set/clear bits, pending_cnt and sb_err, parametrised by REG_FILE_DEPTH, and is instantiated once.
- Storage, write-priority and read/bypass muxes are generate loops in the top module.

Test Plan:
1. Reset then read all addresses on every port -> rd_data = 0, rd_busy = 0, pending_cnt = 0, sb_err = 0.
2. alu_we, addr 5, data 0xDEADBEEF, with rd_addr[0] = 5 the same cycle:
   - BYPASS_EN=1: 0xDEADBEEF that cycle.
   - BYPASS_EN=0: old value 0, then 0xDEADBEEF the next cycle.
   - Also write 0x1234 to x0 -> reads 0 forever.
3. Simultaneous alu_we and mem_we to addr 7 (0x1111 / 0x2222) -> reg 7 = 0x2222, sb_err = 1 and stays 1 until rst.
4. sb_set addr 3 -> next cycle rd_busy = 1, pending_cnt = 1. mem_we addr 3, data 0xCAFE, with rd_addr = 3 that cycle -> rd_busy = 0 (bypass), rd_data = 0xCAFE; next cycle pending_cnt = 0.
5. sb_set addr 9 with mem_we addr 9 the same cycle (bit 9 already set) -> bit 9 stays set, pending_cnt unchanged, reg 9 updated, sb_err = 0.
6. Set addresses 1..31 over 31 cycles -> pending_cnt = 31. Assert rst mid-sequence -> next cycle all bits, pending_cnt and registers = 0.
